uart_rx_fifo: RTL and testbench

//  Receive buffer between the UART receiver and the CPU bus. Captures each byte the

---
 rtl/uart_rx_fifo_pkg.sv | 31 +++
 rtl/uart_rx_fifo_ram.sv | 29 ++
 rtl/uart_rx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO.
// Contents: bus register addresses, STATUS bit positions and the STATUS
// byte packing helper. There are no ports.
package uart_rx_fifo_pkg;

    // Register select values on i_addr
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS byte layout
    localparam int ST_NE     = 0;
    localparam int ST_OV     = 1;
    localparam int ST_FULL   = 2;
    localparam int ST_CNT_LO = 3;
    localparam int ST_CNT_HI = 7;
    localparam int ST_CNT_W  = ST_CNT_HI - ST_CNT_LO + 1;

    function automatic logic [7:0] pack_status(input logic [ST_CNT_W-1:0] cnt,
                                               input logic full,
                                               input logic ov,
                                               input logic ne);
        logic [7:0] s;
        s                      = '0;
        s[ST_CNT_HI:ST_CNT_LO] = cnt;
        s[ST_FULL]             = full;
        s[ST_OV]               = ov;
        s[ST_NE]               = ne;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// DEPTH x 8 storage for the receive FIFO.
// Ports: i_clk        write clock
//        i_we         write enable
//        i_waddr      write address
//        i_wdat       write data
//        i_raddr      read address (asynchronous read)
//        o_rdat       read data
// Storage is deliberately not reset.
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdat,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdat
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdat;
    end

    assign o_rdat = mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the CPU bus.
// Ports: i_clk      system clock
//        i_reset_n  asynchronous active-low reset
//        i_rx_dat   received byte, valid with i_rx_stb
//        i_rx_stb   one-cycle push strobe
//        i_addr     register select (0 = DATA, 1 = STATUS)
//        i_we       bus write enable
//        i_cyc      bus cycle active, may be held several clocks
//        i_wdat0    bit 0 of the bus write data (the STATUS flush bit)
//        o_dat      combinational read data of the selected register
//        o_int      registered level interrupt, count >= THRESH
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int THRESH = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_rx_dat,
    input  logic       i_rx_stb,
    input  logic       i_addr,
    input  logic       i_we,
    input  logic       i_cyc,
    input  logic       i_wdat0,
    output logic [7:0] o_dat,
    output logic       o_int
);

    localparam int        AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_THR  = (AW+1)'(THRESH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ov_q, ov_d;
    logic          dr_acc_q, sr_acc_q, sw_acc_q;
    logic          int_q;

    logic       dr_acc, sr_acc, sw_acc;
    logic       dr_edge, sr_edge, flush;
    logic       full, empty, push, pop, overrun;
    logic [7:0] head;

    // Bus accesses act only on their first cycle, so a held i_cyc acts once.
    assign dr_acc  = i_cyc & ~i_we & (i_addr == REG_DATA);
    assign sr_acc  = i_cyc & ~i_we & (i_addr == REG_STATUS);
    assign sw_acc  = i_cyc &  i_we & (i_addr == REG_STATUS);
    assign dr_edge = dr_acc & ~dr_acc_q;
    assign sr_edge = sr_acc & ~sr_acc_q;
    assign flush   = sw_acc & ~sw_acc_q & i_wdat0;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign pop     = dr_edge & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = i_rx_stb & (~full | pop);
    assign overrun = i_rx_stb & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ov_d     = ov_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ov_d     = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
            // A new overrun outranks the read-to-clear.
            if (overrun)      ov_d = 1'b1;
            else if (sr_edge) ov_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
            dr_acc_q <= 1'b0;
            sr_acc_q <= 1'b0;
            sw_acc_q <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ov_q     <= ov_d;
            dr_acc_q <= dr_acc;
            sr_acc_q <= sr_acc;
            sw_acc_q <= sw_acc;
            int_q    <= (count_d >= CNT_THR);
        end
    end

    uart_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (push & ~flush),
        .i_waddr (wr_ptr_q),
        .i_wdat  (i_rx_dat),
        .i_raddr (rd_ptr_q),
        .o_rdat  (head)
    );

    // Head byte is presented during the access cycle, before the pop edge lands.
    always_comb begin
        o_dat = 8'h00;
        if (i_addr == REG_DATA) o_dat = empty ? 8'h00 : head;
        else o_dat = pack_status(ST_CNT_W'(count_q), full, ov_q, ~empty);
    end

    assign o_int = int_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int THRESH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic       rx_stb = 1'b0;
    logic       addr = 1'b0;
    logic       we = 1'b0;
    logic       cyc = 1'b0;
    logic       wdat0 = 1'b0;
    logic [7:0] o_dat;
    logic       o_int;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_rx_dat  (rx_dat),
        .i_rx_stb  (rx_stb),
        .i_addr    (addr),
        .i_we      (we),
        .i_cyc     (cyc),
        .i_wdat0   (wdat0),
        .o_dat     (o_dat),
        .o_int     (o_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a byte queue plus flags ----------------
    logic [7:0] q[$];
    bit m_ov, m_int, p_dr, p_sr, p_sw;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ov = 0; m_int = 0; p_dr = 0; p_sr = 0; p_sw = 0;
        end else begin : mdl
            bit dr, sr, sw, dre, sre, swe, do_pop, was_full;
            dr  = cyc && !we && addr == 1'b0;
            sr  = cyc && !we && addr == 1'b1;
            sw  = cyc &&  we && addr == 1'b1;
            dre = dr && !p_dr;
            sre = sr && !p_sr;
            swe = sw && !p_sw;
            p_dr = dr; p_sr = sr; p_sw = sw;
            if (swe && wdat0) begin
                q.delete();
                m_ov = 0;
            end else begin
                was_full = (q.size() == DEPTH);
                do_pop   = dre && q.size() != 0;
                if (do_pop) void'(q.pop_front());
                if (rx_stb) begin
                    if (!was_full || do_pop) q.push_back(rx_dat);
                    else m_ov = 1;
                end
                if (!(rx_stb && was_full && !do_pop) && sre) m_ov = 0;
            end
            m_int = (q.size() >= THRESH);
        end
    end

    function automatic logic [7:0] exp_dat();
        if (addr == 1'b0) return (q.size() == 0) ? 8'h00 : q[0];
        return {5'(q.size()), q.size() == DEPTH, m_ov, q.size() != 0};
    endfunction

    // Continuous compare, mid-cycle, against the model
    always @(negedge clk) begin
        check("o_dat", o_dat, exp_dat());
        check("o_int", {7'b0, o_int}, {7'b0, m_int});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_stb = 1'b1; rx_dat = b;
        tick();
        rx_stb = 1'b0;
    endtask

    task automatic read_data(output logic [7:0] v);
        addr = 1'b0; we = 1'b0; cyc = 1'b1;
        @(negedge clk); v = o_dat;
        @(posedge clk); #1;
        repeat (3) tick();
        cyc = 1'b0;
        tick();
    endtask

    task automatic read_status(output logic [7:0] v);
        addr = 1'b1; we = 1'b0; cyc = 1'b1;
        @(negedge clk); v = o_dat;
        @(posedge clk); #1;
        cyc = 1'b0;
        tick();
    endtask

    logic [7:0] v;
    int hold;

    initial begin
        // Reset state
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        read_status(v); check("reset_status", v, 8'h00);
        check("reset_int", {7'b0, o_int}, 8'h00);

        // Basic push/pop
        push(8'h41); push(8'h42); push(8'h43);
        read_status(v); check("status_3", v, 8'h19);
        read_data(v); check("rd_41", v, 8'h41);
        read_data(v); check("rd_42", v, 8'h42);
        read_data(v); check("rd_43", v, 8'h43);
        read_data(v); check("rd_empty", v, 8'h00);
        read_status(v); check("status_empty", v, 8'h00);

        // Interrupt threshold
        push(8'h31); push(8'h32); push(8'h33);
        check("int_below", {7'b0, o_int}, 8'h00);
        push(8'h34);
        check("int_rise", {7'b0, o_int}, 8'h01);
        addr = 1'b0; we = 1'b0; cyc = 1'b1;
        @(negedge clk); check("int_hd", o_dat, 8'h31);
        check("int_before_pop", {7'b0, o_int}, 8'h01);
        @(posedge clk); #1;
        check("int_fall", {7'b0, o_int}, 8'h00);
        repeat (3) tick();
        cyc = 1'b0; tick();
        read_data(v); check("rd_32", v, 8'h32);
        read_data(v); check("rd_33", v, 8'h33);
        read_data(v); check("rd_34", v, 8'h34);

        // Overrun and full
        for (int i = 0; i <= 16; i++) push(8'(i));
        read_status(v); check("status_ovf", v, 8'h87);
        read_status(v); check("status_ov_clr", v, 8'h85);
        // Push coincident with pop edge while full
        addr = 1'b0; we = 1'b0; cyc = 1'b1; rx_stb = 1'b1; rx_dat = 8'hAA;
        @(negedge clk); check("full_head", o_dat, 8'h00);
        @(posedge clk); #1;
        rx_stb = 1'b0;
        repeat (2) tick();
        cyc = 1'b0; tick();
        read_status(v); check("full_swap", v, 8'h85);
        for (int i = 1; i < 16; i++) begin
            read_data(v); check("drain", v, 8'(i));
        end
        read_data(v); check("drain_aa", v, 8'hAA);
        read_status(v); check("drained", v, 8'h00);

        // Reset mid-operation, checked before any clock edge
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
        check("pre_rst_int", {7'b0, o_int}, 8'h01);
        addr = 1'b1; cyc = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_status", o_dat, 8'h00);
        check("async_int", {7'b0, o_int}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        read_data(v); check("rst_data", v, 8'h00);

        // Flush with coincident strobe
        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
        addr = 1'b1; we = 1'b1; wdat0 = 1'b1; cyc = 1'b1; rx_stb = 1'b1; rx_dat = 8'h55;
        tick();
        cyc = 1'b0; we = 1'b0; wdat0 = 1'b0; rx_stb = 1'b0;
        check("flush_int", {7'b0, o_int}, 8'h00);
        tick();
        read_status(v); check("flush_status", v, 8'h00);
        read_data(v); check("flush_data", v, 8'h00);

        // Randomized traffic against the model
        hold = 0;
        for (int n = 0; n < 4000; n++) begin
            rx_stb = ($urandom_range(0, 99) < 45);
            rx_dat = 8'($urandom);
            if (hold > 0) begin
                hold--;
                if (hold == 0) cyc = 1'b0;
            end else if ($urandom_range(0, 99) < 35) begin
                cyc   = 1'b1;
                addr  = 1'($urandom);
                we    = ($urandom_range(0, 99) < 8);
                wdat0 = 1'($urandom);
                hold  = $urandom_range(1, 3);
            end
            tick();
        end
        cyc = 1'b0; rx_stb = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
